// File: rtl/dino_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// dino_ctrl_sequencer
// Front-end controller for the dinogame core. Synchronises and debounces the
// pad inputs, runs the game-level FSM (IDLE/RUN/PAUSE/OVER) and drives the
// core's halt/reset/jump/config inputs. State changes other than a collision
// take effect only on frame boundaries (frame_tick), so the core never sees a
// change mid-frame.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   jump_btn, halt_btn  raw asynchronous buttons
//   cfg_sel, cfg_bus    raw config select / bus ([7:4] accel, [3:0] speed)
//   vsync_in            core vsync (clk-synchronous, polarity VS_ACTIVE_LOW)
//   collision_in        core collision flag (clk-synchronous)
//   jump_pulse          one-cycle jump strobe to core (RUN only)
//   halt_out            freeze core (PAUSE or OVER)
//   game_rst            hold core in reset (IDLE)
//   cfg_accel/cfg_speed config to core, updated on frame_tick only
//   state               FSM state for debug (0 IDLE,1 RUN,2 PAUSE,3 OVER)
// -----------------------------------------------------------------------------
module dino_ctrl_sequencer #(
  parameter int         DEBOUNCE       = 16,
  parameter int         HOLDOFF_FRAMES = 30,
  parameter logic [3:0] DEF_ACCEL      = 4'd4,
  parameter logic [3:0] DEF_SPEED      = 4'd2,
  parameter bit         VS_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       jump_btn,
  input  logic       halt_btn,
  input  logic       cfg_sel,
  input  logic [7:0] cfg_bus,
  input  logic       vsync_in,
  input  logic       collision_in,
  output logic       jump_pulse,
  output logic       halt_out,
  output logic       game_rst,
  output logic [3:0] cfg_accel,
  output logic [3:0] cfg_speed,
  output logic [1:0] state
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int HO_W = $clog2(HOLDOFF_FRAMES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0] DB_ZERO = '0;
  localparam logic [HO_W-1:0] HO_MAX  = HO_W'(HOLDOFF_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // One debounce step: returns {debounced, counter}. The value flips once the
  // synced input has differed for DEBOUNCE consecutive cycles.
  function automatic logic [DB_W:0] db_next(input logic s, input logic d,
                                            input logic [DB_W-1:0] c);
    if (s == d)            return {d, DB_ZERO};
    else if (c == DB_LAST) return {~d, DB_ZERO};
    else                   return {d, c + 1'b1};
  endfunction

  // A zero speed would stall the game, so it is latched as 1.
  function automatic logic [3:0] clamp_speed(input logic [3:0] s);
    return (s == 4'd0) ? 4'd1 : s;
  endfunction

  logic [10:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic            jump_deb_q, jump_deb_d, halt_deb_q, halt_deb_d;
  logic [DB_W-1:0] jump_cnt_q, jump_cnt_d, halt_cnt_q, halt_cnt_d;
  logic            vs_act_q, vs_act_d, frame_tick_q, frame_tick_d;
  state_t          state_q, state_d;
  logic            start_pend_q, start_pend_d;
  logic [HO_W-1:0] holdoff_q, holdoff_d;
  logic            jump_pulse_q, jump_pulse_d;
  logic            halt_out_q, halt_out_d;
  logic            game_rst_q, game_rst_d;
  logic [3:0]      cfg_accel_q, cfg_accel_d, cfg_speed_q, cfg_speed_d;

  logic            jump_edge;
  logic            holdoff_done;
  logic            vs_act;

  assign vs_act = VS_ACTIVE_LOW ? ~vsync_in : vsync_in;

  always_comb begin
    sync1_d      = {jump_btn, halt_btn, cfg_sel, cfg_bus};
    sync2_d      = sync1_q;
    {jump_deb_d, jump_cnt_d} = db_next(sync2_q[10], jump_deb_q, jump_cnt_q);
    {halt_deb_d, halt_cnt_d} = db_next(sync2_q[9],  halt_deb_q, halt_cnt_q);
    // Rising debounced edge, seen in the cycle the debounced value flips.
    jump_edge    = jump_deb_d & ~jump_deb_q;

    // frame_tick is high the cycle after vsync enters its active level.
    vs_act_d     = vs_act;
    frame_tick_d = vs_act & ~vs_act_q;

    holdoff_done = (holdoff_q == HO_MAX);

    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (frame_tick_q && start_pend_q) state_d = ST_RUN;
      ST_RUN: begin
        // Collision does not wait for a frame boundary and beats halt.
        if (collision_in)                     state_d = ST_OVER;
        else if (frame_tick_q && halt_deb_q)  state_d = ST_PAUSE;
      end
      ST_PAUSE: if (frame_tick_q && !halt_deb_q)  state_d = ST_RUN;
      ST_OVER:  if (frame_tick_q && start_pend_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    start_pend_d = start_pend_q;
    if (state_d != state_q)
      start_pend_d = 1'b0;
    else if (jump_edge && ((state_q == ST_IDLE) ||
                           ((state_q == ST_OVER) && holdoff_done)))
      start_pend_d = 1'b1;

    holdoff_d = holdoff_q;
    if ((state_d == ST_OVER) && (state_q != ST_OVER))
      holdoff_d = '0;
    else if ((state_q == ST_OVER) && frame_tick_q && !holdoff_done)
      holdoff_d = holdoff_q + 1'b1;

    // Outputs follow the next state so they change together with state.
    game_rst_d   = (state_d == ST_IDLE);
    halt_out_d   = (state_d == ST_PAUSE) || (state_d == ST_OVER);
    jump_pulse_d = jump_edge && (state_q == ST_RUN) && (state_d == ST_RUN);

    cfg_accel_d = cfg_accel_q;
    cfg_speed_d = cfg_speed_q;
    if (frame_tick_q) begin
      if (sync2_q[8]) begin
        cfg_accel_d = sync2_q[7:4];
        cfg_speed_d = clamp_speed(sync2_q[3:0]);
      end else begin
        cfg_accel_d = DEF_ACCEL;
        cfg_speed_d = DEF_SPEED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      jump_deb_q   <= 1'b0;
      halt_deb_q   <= 1'b0;
      jump_cnt_q   <= '0;
      halt_cnt_q   <= '0;
      vs_act_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      state_q      <= ST_IDLE;
      start_pend_q <= 1'b0;
      holdoff_q    <= '0;
      jump_pulse_q <= 1'b0;
      halt_out_q   <= 1'b0;
      game_rst_q   <= 1'b1;
      cfg_accel_q  <= DEF_ACCEL;
      cfg_speed_q  <= DEF_SPEED;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      jump_deb_q   <= jump_deb_d;
      halt_deb_q   <= halt_deb_d;
      jump_cnt_q   <= jump_cnt_d;
      halt_cnt_q   <= halt_cnt_d;
      vs_act_q     <= vs_act_d;
      frame_tick_q <= frame_tick_d;
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      holdoff_q    <= holdoff_d;
      jump_pulse_q <= jump_pulse_d;
      halt_out_q   <= halt_out_d;
      game_rst_q   <= game_rst_d;
      cfg_accel_q  <= cfg_accel_d;
      cfg_speed_q  <= cfg_speed_d;
    end
  end

  assign jump_pulse = jump_pulse_q;
  assign halt_out   = halt_out_q;
  assign game_rst   = game_rst_q;
  assign cfg_accel  = cfg_accel_q;
  assign cfg_speed  = cfg_speed_q;
  assign state      = state_q;

endmodule

// File: tb/tb_dino_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dino_ctrl_sequencer
// Directed bench for dino_ctrl_sequencer with DEBOUNCE=4, HOLDOFF_FRAMES=3.
// Expected output snapshots are queued as stimulus is applied and compared
// against the DUT once the stimulus has had its effect.
// -----------------------------------------------------------------------------
module tb_dino_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       jump_btn, halt_btn, cfg_sel;
  logic [7:0] cfg_bus;
  logic       vsync_in, collision_in;
  logic       jump_pulse, halt_out, game_rst;
  logic [3:0] cfg_accel, cfg_speed;
  logic [1:0] state;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       gr;
    logic       ho;
    logic       jp;
    logic [3:0] acc;
    logic [3:0] spd;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];

  dino_ctrl_sequencer #(
    .DEBOUNCE(4),
    .HOLDOFF_FRAMES(3),
    .DEF_ACCEL(4'd4),
    .DEF_SPEED(4'd2),
    .VS_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .jump_btn(jump_btn),
    .halt_btn(halt_btn),
    .cfg_sel(cfg_sel),
    .cfg_bus(cfg_bus),
    .vsync_in(vsync_in),
    .collision_in(collision_in),
    .jump_pulse(jump_pulse),
    .halt_out(halt_out),
    .game_rst(game_rst),
    .cfg_accel(cfg_accel),
    .cfg_speed(cfg_speed),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // vsync low for one cycle; the state change lands on the second posedge.
  task automatic frame();
    vsync_in = 1'b0;
    tick(1);
    vsync_in = 1'b1;
    tick(1);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] st, input logic gr,
                      input logic ho, input logic jp, input logic [3:0] acc,
                      input logic [3:0] spd);
    exp_t e;
    e.st = st; e.gr = gr; e.ho = ho; e.jp = jp; e.acc = acc; e.spd = spd;
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    e = sb.pop_front();
    t = tag_q.pop_front();
    chk({t, ".state"},      {6'b0, state},      {6'b0, e.st});
    chk({t, ".game_rst"},   {7'b0, game_rst},   {7'b0, e.gr});
    chk({t, ".halt_out"},   {7'b0, halt_out},   {7'b0, e.ho});
    chk({t, ".jump_pulse"}, {7'b0, jump_pulse}, {7'b0, e.jp});
    chk({t, ".cfg_accel"},  {4'b0, cfg_accel},  {4'b0, e.acc});
    chk({t, ".cfg_speed"},  {4'b0, cfg_speed},  {4'b0, e.spd});
  endtask

  task automatic press_jump();
    jump_btn = 1'b1;
    tick(8);
    jump_btn = 1'b0;
    tick(8);
  endtask

  initial begin
    rst_n = 1'b0; jump_btn = 1'b0; halt_btn = 1'b0; cfg_sel = 1'b0;
    cfg_bus = 8'h00; vsync_in = 1'b1; collision_in = 1'b0;

    // Reset state
    push("reset", 2'd0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd2);
    tick(3);
    pop_check();
    rst_n = 1'b1;
    tick(2);

    // Idle frames with no input
    for (int i = 0; i < 3; i++) begin
      push("idle_frame", 2'd0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd2);
      frame();
      tick(4);
      pop_check();
    end

    // Bouncing jump, then held high; a frame just as the edge appears is too early
    jump_btn = 1'b1; tick(2); jump_btn = 1'b0; tick(2);
    jump_btn = 1'b1; tick(2); jump_btn = 1'b0; tick(2);
    jump_btn = 1'b1;
    tick(4);
    push("bounce_early_frame", 2'd0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd2);
    frame();
    pop_check();
    push("start_run", 2'd1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd2);
    frame();
    pop_check();
    tick(2);
    jump_btn = 1'b0;
    push("run_release", 2'd1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd2);
    tick(8);
    pop_check();

    // Jump in RUN: pulse exactly one cycle, 6 cycles after the press
    jump_btn = 1'b1;
    push("jp_before", 2'd1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd2);
    tick(5);
    pop_check();
    push("jp_high", 2'd1, 1'b0, 1'b0, 1'b1, 4'd4, 4'd2);
    tick(1);
    pop_check();
    push("jp_after", 2'd1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd2);
    tick(1);
    pop_check();
    jump_btn = 1'b0;
    tick(8);

    // Halt mid-frame waits for frame_tick; release returns to RUN
    halt_btn = 1'b1;
    push("halt_midframe", 2'd1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd2);
    tick(8);
    pop_check();
    push("pause", 2'd2, 1'b0, 1'b1, 1'b0, 4'd4, 4'd2);
    frame();
    pop_check();
    halt_btn = 1'b0;
    push("unhalt_midframe", 2'd2, 1'b0, 1'b1, 1'b0, 4'd4, 4'd2);
    tick(8);
    pop_check();
    push("resume", 2'd1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd2);
    frame();
    pop_check();

    // Collision and halted frame_tick together: collision wins
    halt_btn = 1'b1;
    tick(8);
    vsync_in = 1'b0;
    tick(1);
    vsync_in = 1'b1;
    collision_in = 1'b1;
    push("collide_over", 2'd3, 1'b0, 1'b1, 1'b0, 4'd4, 4'd2);
    tick(1);
    collision_in = 1'b0;
    pop_check();
    halt_btn = 1'b0;
    tick(8);

    // Holdoff: jump during frame 1 ignored; jump after frame 3 restarts
    frame();
    press_jump();
    push("holdoff_f2", 2'd3, 1'b0, 1'b1, 1'b0, 4'd4, 4'd2);
    frame();
    pop_check();
    push("holdoff_f3", 2'd3, 1'b0, 1'b1, 1'b0, 4'd4, 4'd2);
    frame();
    pop_check();
    push("holdoff_jump", 2'd3, 1'b0, 1'b1, 1'b0, 4'd4, 4'd2);
    press_jump();
    pop_check();
    push("over_to_idle", 2'd0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd2);
    frame();
    pop_check();
    push("idle_pending", 2'd0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd2);
    press_jump();
    pop_check();
    push("restart_run", 2'd1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd2);
    frame();
    pop_check();

    // Config latching on frame_tick only, speed 0 clamps to 1
    cfg_sel = 1'b1; cfg_bus = 8'h70;
    push("cfg_hold", 2'd1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd2);
    tick(5);
    pop_check();
    push("cfg_70", 2'd1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd1);
    frame();
    pop_check();
    cfg_bus = 8'h35;
    push("cfg_hold2", 2'd1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd1);
    tick(5);
    pop_check();
    push("cfg_35", 2'd1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd5);
    frame();
    pop_check();
    cfg_bus = 8'h00;
    tick(4);
    push("cfg_00", 2'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1);
    frame();
    pop_check();
    cfg_sel = 1'b0; cfg_bus = 8'h70;
    tick(4);
    push("cfg_default", 2'd1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd2);
    frame();
    pop_check();
    cfg_sel = 1'b1;
    tick(4);
    push("cfg_70_again", 2'd1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd1);
    frame();
    pop_check();

    // Short asynchronous reset while paused
    halt_btn = 1'b1;
    tick(8);
    push("pause_cfg", 2'd2, 1'b0, 1'b1, 1'b0, 4'd7, 4'd1);
    frame();
    pop_check();
    @(posedge clk);
    #2 rst_n = 1'b0;
    push("async_reset", 2'd0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd2);
    #1 pop_check();
    #2 rst_n = 1'b1;
    halt_btn = 1'b0; cfg_sel = 1'b0;
    push("post_reset", 2'd0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd2);
    tick(3);
    pop_check();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
